// File: rtl/qrd_sequencer_if.sv
// Bundle of the command, vector-stream, status and QRD_Unit signals around qrd_sequencer.
// The slave modport is the sequencer side; the master modport is the AFU/QRD_Unit side.
interface qrd_sequencer_if #(
  parameter int LANES = 8,
  parameter int ROW_W = 6,
  parameter int COL_W = 5
);
  localparam int DW = 32 * LANES;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [ROW_W-1:0] cmd_rows;
  logic [COL_W-1:0] cmd_cols;
  logic [1:0]       cmd_op;
  logic             cmd_used_pus;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;

  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;

  logic             busy;
  logic             status_done;
  logic             status_timeout;
  logic             status_error;

  logic             q_write_req_valid;
  logic             q_write_req_bits;
  logic [ROW_W-1:0] q_write_row;
  logic [COL_W-1:0] q_write_column;
  logic [DW-1:0]    q_write_input;

  logic             q_read_req;
  logic [ROW_W-1:0] q_read_row;
  logic [COL_W-1:0] q_read_column;
  logic             q_read_output_valid;
  logic [DW-1:0]    q_read_output;

  logic             q_op_valid;
  logic [1:0]       q_op_bits;
  logic             q_used_pus_valid;
  logic             q_used_pus_bits;
  logic             q_lengths_valid;
  logic [ROW_W-1:0] q_lengths_bits_0;
  logic [ROW_W-1:0] q_lengths_bits_1;
  logic             q_done;

  modport slave (
    input  cmd_valid, cmd_rows, cmd_cols, cmd_op, cmd_used_pus,
    input  in_valid, in_data, out_ready,
    input  q_read_output_valid, q_read_output, q_done,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
    output busy, status_done, status_timeout, status_error,
    output q_write_req_valid, q_write_req_bits, q_write_row, q_write_column, q_write_input,
    output q_read_req, q_read_row, q_read_column,
    output q_op_valid, q_op_bits, q_used_pus_valid, q_used_pus_bits,
    output q_lengths_valid, q_lengths_bits_0, q_lengths_bits_1
  );

  modport master (
    output cmd_valid, cmd_rows, cmd_cols, cmd_op, cmd_used_pus,
    output in_valid, in_data, out_ready,
    output q_read_output_valid, q_read_output, q_done,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
    input  busy, status_done, status_timeout, status_error,
    input  q_write_req_valid, q_write_req_bits, q_write_row, q_write_column, q_write_input,
    input  q_read_req, q_read_row, q_read_column,
    input  q_op_valid, q_op_bits, q_used_pus_valid, q_used_pus_bits,
    input  q_lengths_valid, q_lengths_bits_0, q_lengths_bits_1
  );
endinterface

// File: rtl/qrd_sequencer.sv
// Drives one QRD_Unit through load, config, launch, wait-for-done and credit-limited readback.
// q_* strobes are registered from the state that issues them; output backpressure via a 2-entry FIFO.
module qrd_sequencer #(
  parameter int LANES     = 8,
  parameter int ROW_W     = 6,
  parameter int COL_W     = 5,
  parameter int TIMEOUT_W = 20
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  qrd_sequencer_if.slave io_bus
);
  localparam int DW = 32 * LANES;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONFIG, S_LAUNCH, S_WAIT_DONE, S_READ
  } state_t;

  state_t               r_state;
  logic                 r_cmd_ready;
  logic [ROW_W-1:0]     r_rows;
  logic [COL_W-1:0]     r_cols;
  logic [1:0]           r_op;
  logic                 r_pus;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [1:0]           r_outstanding;
  logic                 r_issue_done;
  logic [DW:0]          r_fifo0;
  logic [DW:0]          r_fifo1;
  logic [1:0]           r_fifo_cnt;
  logic                 r_fifo_rd;

  logic                 r_status_done;
  logic                 r_status_timeout;
  logic                 r_status_error;
  logic                 r_q_write_req_valid;
  logic                 r_q_write_req_bits;
  logic [ROW_W-1:0]     r_q_write_row;
  logic [COL_W-1:0]     r_q_write_column;
  logic [DW-1:0]        r_q_write_input;
  logic                 r_q_read_req;
  logic [ROW_W-1:0]     r_q_read_row;
  logic [COL_W-1:0]     r_q_read_column;
  logic                 r_q_op_valid;
  logic [1:0]           r_q_op_bits;
  logic                 r_q_used_pus_valid;
  logic                 r_q_used_pus_bits;
  logic                 r_q_lengths_valid;
  logic [ROW_W-1:0]     r_q_lengths_bits_0;
  logic [ROW_W-1:0]     r_q_lengths_bits_1;

  logic                 w_cmd_fire;
  logic                 w_cmd_bad;
  logic                 w_in_fire;
  logic                 w_row_last;
  logic                 w_elem_last;
  logic                 w_credit_ok;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_push_last;
  logic                 w_pop;
  logic                 w_wr_slot;
  logic [DW:0]          w_head;
  logic [TIMEOUT_W-1:0] w_wd_next;

  assign w_cmd_fire  = io_bus.cmd_valid & r_cmd_ready;
  assign w_cmd_bad   = (io_bus.cmd_rows == '0) | (io_bus.cmd_cols == '0);
  assign w_in_fire   = io_bus.in_valid & (r_state == S_LOAD);
  assign w_row_last  = (r_row == (r_rows - 1'b1));
  assign w_elem_last = w_row_last & (r_col == (r_cols - 1'b1));
  // Credit counts both queued results and reads still in flight, so the FIFO can never overflow.
  assign w_credit_ok = ({1'b0, r_fifo_cnt} + {1'b0, r_outstanding}) < 3'd2;
  assign w_issue     = (r_state == S_READ) & ~r_issue_done & w_credit_ok;
  assign w_push      = io_bus.q_read_output_valid & (r_outstanding != 2'd0);
  assign w_push_last = r_issue_done & (r_outstanding == 2'd1);
  assign w_pop       = (r_fifo_cnt != 2'd0) & io_bus.out_ready;
  assign w_wr_slot   = r_fifo_rd ^ r_fifo_cnt[0];
  assign w_head      = r_fifo_rd ? r_fifo1 : r_fifo0;
  assign w_wd_next   = r_wd + 1'b1;

  assign io_bus.cmd_ready         = r_cmd_ready;
  assign io_bus.in_ready          = (r_state == S_LOAD);
  assign io_bus.out_valid         = (r_fifo_cnt != 2'd0);
  assign io_bus.out_data          = w_head[DW:1];
  assign io_bus.out_last          = w_head[0];
  assign io_bus.busy              = (r_state != S_IDLE);
  assign io_bus.status_done       = r_status_done;
  assign io_bus.status_timeout    = r_status_timeout;
  assign io_bus.status_error      = r_status_error;
  assign io_bus.q_write_req_valid = r_q_write_req_valid;
  assign io_bus.q_write_req_bits  = r_q_write_req_bits;
  assign io_bus.q_write_row       = r_q_write_row;
  assign io_bus.q_write_column    = r_q_write_column;
  assign io_bus.q_write_input     = r_q_write_input;
  assign io_bus.q_read_req        = r_q_read_req;
  assign io_bus.q_read_row        = r_q_read_row;
  assign io_bus.q_read_column     = r_q_read_column;
  assign io_bus.q_op_valid        = r_q_op_valid;
  assign io_bus.q_op_bits         = r_q_op_bits;
  assign io_bus.q_used_pus_valid  = r_q_used_pus_valid;
  assign io_bus.q_used_pus_bits   = r_q_used_pus_bits;
  assign io_bus.q_lengths_valid   = r_q_lengths_valid;
  assign io_bus.q_lengths_bits_0  = r_q_lengths_bits_0;
  assign io_bus.q_lengths_bits_1  = r_q_lengths_bits_1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state             <= S_IDLE;
      r_cmd_ready         <= 1'b0;
      r_rows              <= '0;
      r_cols              <= '0;
      r_op                <= '0;
      r_pus               <= 1'b0;
      r_row               <= '0;
      r_col               <= '0;
      r_wd                <= '0;
      r_outstanding       <= '0;
      r_issue_done        <= 1'b0;
      r_fifo0             <= '0;
      r_fifo1             <= '0;
      r_fifo_cnt          <= '0;
      r_fifo_rd           <= 1'b0;
      r_status_done       <= 1'b0;
      r_status_timeout    <= 1'b0;
      r_status_error      <= 1'b0;
      r_q_write_req_valid <= 1'b0;
      r_q_write_req_bits  <= 1'b0;
      r_q_write_row       <= '0;
      r_q_write_column    <= '0;
      r_q_write_input     <= '0;
      r_q_read_req        <= 1'b0;
      r_q_read_row        <= '0;
      r_q_read_column     <= '0;
      r_q_op_valid        <= 1'b0;
      r_q_op_bits         <= '0;
      r_q_used_pus_valid  <= 1'b0;
      r_q_used_pus_bits   <= 1'b0;
      r_q_lengths_valid   <= 1'b0;
      r_q_lengths_bits_0  <= '0;
      r_q_lengths_bits_1  <= '0;
    end else begin
      r_status_done       <= 1'b0;
      r_status_timeout    <= 1'b0;
      r_status_error      <= 1'b0;
      r_q_write_req_valid <= 1'b0;
      r_q_write_req_bits  <= 1'b0;
      r_q_read_req        <= 1'b0;
      r_q_op_valid        <= 1'b0;
      r_q_used_pus_valid  <= 1'b0;
      r_q_lengths_valid   <= 1'b0;

      if (w_push) begin
        if (w_wr_slot) r_fifo1 <= {io_bus.q_read_output, w_push_last};
        else           r_fifo0 <= {io_bus.q_read_output, w_push_last};
      end
      if (w_pop) r_fifo_rd <= ~r_fifo_rd;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};

      if (w_issue && !w_push)      r_outstanding <= r_outstanding + 2'd1;
      else if (!w_issue && w_push) r_outstanding <= r_outstanding - 2'd1;

      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            if (w_cmd_bad) begin
              r_status_error <= 1'b1;
            end else begin
              r_rows       <= io_bus.cmd_rows;
              r_cols       <= io_bus.cmd_cols;
              r_op         <= io_bus.cmd_op;
              r_pus        <= io_bus.cmd_used_pus;
              r_row        <= '0;
              r_col        <= '0;
              r_issue_done <= 1'b0;
              r_cmd_ready  <= 1'b0;
              r_state      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_in_fire) begin
            r_q_write_req_valid <= 1'b1;
            r_q_write_req_bits  <= 1'b1;
            r_q_write_row       <= r_row;
            r_q_write_column    <= r_col;
            r_q_write_input     <= io_bus.in_data;
            if (w_elem_last) begin
              r_row   <= '0;
              r_col   <= '0;
              r_state <= S_CONFIG;
            end else if (w_row_last) begin
              r_row <= '0;
              r_col <= r_col + 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        S_CONFIG: begin
          r_q_used_pus_valid <= 1'b1;
          r_q_used_pus_bits  <= r_pus;
          r_q_lengths_valid  <= 1'b1;
          r_q_lengths_bits_0 <= r_rows;
          r_q_lengths_bits_1 <= ROW_W'(r_cols);
          r_state            <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_q_op_valid <= 1'b1;
          r_q_op_bits  <= r_op;
          r_wd         <= '0;
          r_state      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (io_bus.q_done) begin
            r_state <= S_READ;
          end else if (&w_wd_next) begin
            r_status_timeout <= 1'b1;
            r_cmd_ready      <= 1'b1;
            r_state          <= S_IDLE;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_q_read_req    <= 1'b1;
            r_q_read_row    <= r_row;
            r_q_read_column <= r_col;
            if (w_elem_last) begin
              r_issue_done <= 1'b1;
            end else if (w_row_last) begin
              r_row <= '0;
              r_col <= r_col + 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
          if (r_issue_done && (r_outstanding == 2'd0) && (r_fifo_cnt == 2'd0)) begin
            r_status_done <= 1'b1;
            r_issue_done  <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qrd_sequencer.sv
// Directed bench for qrd_sequencer: a behavioural QRD_Unit memory answers reads one cycle late.
// Monitors log every q_* strobe at the falling edge; the main initial block checks the logs.
module tb_qrd_sequencer;
  localparam int LANES = 8, ROW_W = 6, COL_W = 5, TIMEOUT_W = 4, DW = 32 * LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qrd_sequencer_if #(.LANES(LANES), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  qrd_sequencer #(.LANES(LANES), .ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus.slave)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_wr = 0, n_rd = 0, n_out = 0, n_len = 0, n_pus = 0, n_op = 0;
  int n_done = 0, n_to = 0, n_err = 0, n_wbits_bad = 0;
  int len_b0, len_b1, len_cyc, pus_b, pus_cyc, op_b, op_cyc, to_cyc;
  int wr_row_q[$], wr_col_q[$], wr_cyc_q[$], rd_row_q[$], rd_col_q[$];
  logic [DW-1:0] wr_dat_q[$];
  logic [DW-1:0] out_dat_q[$];
  logic          out_last_q[$];
  logic [DW-1:0] mem [64][32];
  logic          rsp_pend = 1'b0;
  logic [DW-1:0] rsp_dat  = '0;
  logic          inj_rsp  = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bus.q_read_output_valid = rsp_pend | inj_rsp;
    bus.q_read_output       = rsp_pend ? rsp_dat : {DW{1'b1}};
    rsp_pend                = bus.q_read_req;
    if (bus.q_read_req) begin
      rsp_dat = mem[bus.q_read_row][bus.q_read_column];
      rd_row_q.push_back(int'(bus.q_read_row));
      rd_col_q.push_back(int'(bus.q_read_column));
      n_rd++;
    end
    if (bus.q_write_req_valid) begin
      mem[bus.q_write_row][bus.q_write_column] = bus.q_write_input;
      wr_row_q.push_back(int'(bus.q_write_row));
      wr_col_q.push_back(int'(bus.q_write_column));
      wr_cyc_q.push_back(cyc);
      wr_dat_q.push_back(bus.q_write_input);
      if (bus.q_write_req_bits !== 1'b1) n_wbits_bad++;
      n_wr++;
    end
    if (bus.q_lengths_valid) begin
      n_len++; len_b0 = int'(bus.q_lengths_bits_0); len_b1 = int'(bus.q_lengths_bits_1); len_cyc = cyc;
    end
    if (bus.q_used_pus_valid) begin
      n_pus++; pus_b = int'(bus.q_used_pus_bits); pus_cyc = cyc;
    end
    if (bus.q_op_valid) begin
      n_op++; op_b = int'(bus.q_op_bits); op_cyc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      out_dat_q.push_back(bus.out_data);
      out_last_q.push_back(bus.out_last);
      n_out++;
    end
    if (bus.status_done)    n_done++;
    if (bus.status_timeout) begin n_to++; to_cyc = cyc; end
    if (bus.status_error)   n_err++;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [DW-1:0] beat(input int t, input int k);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[32*i +: 32] = 32'((t << 16) | (k << 4) | i);
    return d;
  endfunction

  task automatic send_cmd(input int rows, input int cols, input int op, input int pus);
    int n = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_rows     = ROW_W'(rows);
    bus.cmd_cols     = COL_W'(cols);
    bus.cmd_op       = 2'(op);
    bus.cmd_used_pus = 1'(pus);
    while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("cmd_accept", n < 50, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int t);
    int k = 0, guard = 0;
    logic ok;
    while (k < n && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat(t, k);
      ok = bus.in_ready;
      tick();
      if (ok) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("beats_sent", k, n);
  endtask

  task automatic wait_op(input int op0);
    int g = 0;
    while (n_op == op0 && g < 50) begin tick(); g++; end
    chk("op_seen", n_op - op0, 1);
  endtask

  task automatic run_job(input int rows, input int cols, input int op, input int pus,
                         input int t, input int stall);
    int w0 = n_wr, r0 = n_rd, o0 = n_out, d0 = n_done, l0 = n_len, p0 = n_op, g = 0;
    int ne = rows * cols;
    bus.out_ready = (stall == 0);
    send_cmd(rows, cols, op, pus);
    send_beats(ne, t);
    wait_op(p0);
    chk("len_once", n_len - l0, 1);
    chk("len_bits0", len_b0, rows);
    chk("len_bits1", len_b1, cols);
    chk("pus_bits", pus_b, pus);
    chk("pus_with_len", pus_cyc, len_cyc);
    chk("op_bits", op_b, op);
    chk("op_after_len", op_cyc - len_cyc, 1);
    chk("len_after_write", len_cyc - qget(wr_cyc_q, w0 + ne - 1), 1);
    repeat (4) tick();
    bus.q_done = 1'b1;
    tick();
    bus.q_done = 1'b0;
    if (stall > 0) begin
      repeat (stall) tick();
      chk("stall_reads_max2", (n_rd - r0) <= 2, 1);
      chk("stall_no_output", n_out - o0, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
    end
    while (n_done == d0 && g < 300) begin tick(); g++; end
    repeat (3) tick();
    chk("done_once", n_done - d0, 1);
    chk("write_count", n_wr - w0, ne);
    chk("read_count", n_rd - r0, ne);
    chk("out_count", n_out - o0, ne);
    for (int k = 0; k < ne; k++) begin
      chk("wr_row", qget(wr_row_q, w0 + k), k % rows);
      chk("wr_col", qget(wr_col_q, w0 + k), k / rows);
      chk("wr_b2b", qget(wr_cyc_q, w0 + k) - qget(wr_cyc_q, w0), k);
      chk("wr_data", (w0 + k < wr_dat_q.size()) ? wr_dat_q[w0 + k] : '0, beat(t, k));
      chk("rd_row", qget(rd_row_q, r0 + k), k % rows);
      chk("rd_col", qget(rd_col_q, r0 + k), k / rows);
      chk("out_data", (o0 + k < out_dat_q.size()) ? out_dat_q[o0 + k] : '0, beat(t, k));
      chk("out_last", (o0 + k < out_last_q.size()) ? out_last_q[o0 + k] : 1'bx, k == ne - 1);
    end
    chk("idle_after_job", bus.busy, 0);
    chk("ready_after_job", bus.cmd_ready, 1);
  endtask

  initial begin
    int w0, r0, o0, e0, l0, p0, d0, g;
    bus.cmd_valid = 1'b0; bus.cmd_rows = '0; bus.cmd_cols = '0; bus.cmd_op = '0;
    bus.cmd_used_pus = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b1; bus.q_done = 1'b0;

    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_write_valid", bus.q_write_req_valid, 0);
    chk("rst_op_valid", bus.q_op_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_in_ready", bus.in_ready, 0);

    run_job(1, 1, 2, 1, 1, 0);
    run_job(3, 2, 1, 0, 2, 0);
    run_job(4, 1, 3, 1, 3, 20);

    // Watchdog: q_done withheld, so the terminal count must fire and skip readback.
    r0 = n_rd; o0 = n_out; d0 = n_done; p0 = n_op;
    send_cmd(2, 1, 1, 0);
    send_beats(2, 4);
    wait_op(p0);
    g = 0;
    while (n_to == 0 && g < 100) begin tick(); g++; end
    chk("timeout_seen", n_to, 1);
    chk("timeout_delay", to_cyc - op_cyc, 15);
    chk("timeout_no_reads", n_rd - r0, 0);
    chk("timeout_no_done", n_done - d0, 0);
    chk("timeout_idle", bus.busy, 0);

    inj_rsp = 1'b1;
    tick();
    inj_rsp = 1'b0;
    repeat (2) tick();
    chk("stray_rsp_out_valid", bus.out_valid, 0);
    chk("stray_rsp_no_out", n_out - o0, 0);

    w0 = n_wr; r0 = n_rd; e0 = n_err; l0 = n_len; p0 = n_op;
    send_cmd(0, 2, 1, 0);
    repeat (3) tick();
    chk("err_rows0_pulse", n_err - e0, 1);
    send_cmd(2, 0, 1, 0);
    repeat (3) tick();
    chk("err_cols0_pulse", n_err - e0, 2);
    chk("err_no_write", n_wr - w0, 0);
    chk("err_no_read", n_rd - r0, 0);
    chk("err_no_len", n_len - l0, 0);
    chk("err_no_op", n_op - p0, 0);
    chk("err_idle", bus.busy, 0);
    run_job(2, 2, 0, 1, 5, 0);

    send_cmd(3, 2, 0, 0);
    send_beats(2, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_write_valid", bus.q_write_req_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_lengths_valid", bus.q_lengths_valid, 0);
    chk("arst_read_req", bus.q_read_req, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_job(2, 2, 2, 0, 7, 0);
    chk("write_bits_always_1", n_wbits_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
